pc_source_unit: RTL and testbench
=================================

PC_SOURCE_UNIT -- requirements
Module: pc_source_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC, source and EPC width.
REQ-002 Parameter NSRC, default 4: number of external PC sources; SEL_W = clog2(NSRC+1).
REQ-003 Parameter RESET_PC, default 0: PC value after reset.
REQ-004 Parameter EPC_OFFSET, default 4: subtracted from PC when EPC is captured.
REQ-005 Parameter VEC_BASE, default 253: byte address of exception-vector table entry 0.
REQ-006 Parameter MEM_LAT, default 1 (>=1): memory read latency in cycles.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 pc_sel  in  SEL_W  source select; 0..NSRC-1 external, NSRC selects internal EPC.
REQ-010 src_bus  in  NSRC*WIDTH  flattened sources; source i at bits [i*WIDTH +: WIDTH].
REQ-011 pc_write  in  1  unconditional PC load.
REQ-012 pc_write_cond  in  1  conditional PC load (branch).
REQ-013 cond_true  in  1  branch condition from ALU flags.
REQ-014 exc_req  in  1  exception request, sampled in IDLE only.
REQ-015 exc_cause  in  2  0 invalid opcode, 1 overflow, 2 divide-by-zero; 3 treated as 0.
REQ-016 mem_rdata  in  8  vector byte returned by memory.
REQ-017 pc_out  out  WIDTH  registered PC.
REQ-018 epc_out  out  WIDTH  registered EPC.
REQ-019 mem_req  out  1  vector read request.
REQ-020 mem_addr  out  WIDTH  vector read address.
REQ-021 busy  out  1  high whenever state is not IDLE.
REQ-022 exc_ack  out  1  one-cycle pulse when handler PC is loaded.
REQ-023 sel_err  out  1  one-cycle pulse on PC load with pc_sel > NSRC.

Function
REQ-024 FSM states: IDLE, FETCH, WAIT; encoding free.
REQ-025 IDLE, exc_req=1: epc <= pc_out - EPC_OFFSET (mod 2^WIDTH), cause latched, next FETCH; any PC load that cycle is suppressed.
REQ-026 IDLE, exc_req=0, load = pc_write | (pc_write_cond & cond_true): pc_sel<NSRC loads src i; pc_sel==NSRC loads epc_out; pc_sel>NSRC holds PC and pulses sel_err next cycle.
REQ-027 IDLE, no load: PC holds; selection otherwise combinational on inputs, no extra latency (PC valid the cycle after load asserted).
REQ-028 FETCH: mem_req=1, mem_addr=VEC_BASE+cause for one cycle; latency counter loaded with MEM_LAT-1; next WAIT.
REQ-029 WAIT: mem_req=0; counter decrements each cycle; at counter 0, pc <= zero-extended mem_rdata, exc_ack=1 for that cycle's registered output, next IDLE.
REQ-030 Total exception entry: exc_req cycle to exc_ack = MEM_LAT+2 cycles; busy high for MEM_LAT+1 cycles.
REQ-031 While busy: pc_write, pc_write_cond, exc_req ignored (not queued); EPC not overwritten.
REQ-032 mem_addr = 0 when mem_req=0.
REQ-033 EPC changes only per REQ-025 and reset.

Reset
REQ-034 reset=1 at edge: pc_out=RESET_PC, epc_out=0, state IDLE, counter 0, mem_req=0, mem_addr=0, busy=0, exc_ack=0, sel_err=0.
REQ-035 Reset asserted in FETCH/WAIT aborts exception; no exc_ack; PC and EPC take reset values.
REQ-036 reset has priority over all other inputs in the same cycle.

Verification
REQ-037 Reset, pc_sel=2, src2=0x00400010, pc_write=1 -> pc_out=0x00400010 next cycle, busy=0.
REQ-038 pc_write_cond=1, cond_true=0 then 1, src1=0x80 -> PC holds, then 0x80.
REQ-039 pc_out=0x100, exc_req=1 cause=1, MEM_LAT=1, mem_rdata=0x5C -> epc=0xFC, mem_addr=254 one cycle, pc=0x5C, exc_ack 3 cycles after request; pc_write pulses during busy ignored.
REQ-040 pc_out=0, exc_req cause=2 -> epc=0xFFFFFFFC (wrap); then pc_sel=NSRC, pc_write -> pc=0xFFFFFFFC.
REQ-041 pc_sel=NSRC+1 (legal width), pc_write=1 -> PC unchanged, sel_err single pulse.
REQ-042 Exception in WAIT, reset asserted -> pc=RESET_PC, epc=0, busy=0, no exc_ack.

Source files
------------

// File: rtl/pc_source_unit.sv
// pc_source_unit: selects and holds the PC, captures the EPC, and fetches the exception handler PC from a vector table
module pc_source_unit #(
   parameter int WIDTH = 32,
   parameter int NSRC = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] EPC_OFFSET = WIDTH'(4),
   parameter logic [WIDTH-1:0] VEC_BASE = WIDTH'(253),
   parameter int MEM_LAT = 1,
   localparam int SEL_W = $clog2(NSRC + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SEL_W-1:0]      pc_sel,
   input  logic [NSRC*WIDTH-1:0] src_bus,
   input  logic                  pc_write,
   input  logic                  pc_write_cond,
   input  logic                  cond_true,
   input  logic                  exc_req,
   input  logic [1:0]            exc_cause,
   input  logic [7:0]            mem_rdata,
   output logic [WIDTH-1:0]      pc_out,
   output logic [WIDTH-1:0]      epc_out,
   output logic                  mem_req,
   output logic [WIDTH-1:0]      mem_addr,
   output logic                  busy,
   output logic                  exc_ack,
   output logic                  sel_err
);
   localparam int CW = $clog2(MEM_LAT + 1);
   typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] sel_pc;
   logic load;
   logic [1:0] cause_n;
   assign load = pc_write | (pc_write_cond & cond_true);
   assign cause_n = (exc_cause == 2'd3) ? 2'd0 : exc_cause;
   assign busy = state != IDLE;
   // selects above NSRC never reach sel_pc; they are trapped as sel_err
   always_comb begin
      sel_pc = epc_out;
      for (int i = 0; i < NSRC; i++)
         if (pc_sel == SEL_W'(i)) sel_pc = src_bus[i*WIDTH +: WIDTH];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pc_out   <= RESET_PC;
         epc_out  <= '0;
         cnt      <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         exc_ack  <= 1'b0;
         sel_err  <= 1'b0;
      end else begin
         exc_ack  <= 1'b0;
         sel_err  <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         case (state)
            IDLE: begin
               if (exc_req) begin
                  epc_out  <= pc_out - EPC_OFFSET;
                  mem_req  <= 1'b1;
                  mem_addr <= VEC_BASE + WIDTH'(cause_n);
                  state    <= FETCH;
               end else if (load) begin
                  if (pc_sel > SEL_W'(NSRC)) sel_err <= 1'b1;
                  else pc_out <= sel_pc;
               end
            end
            FETCH: begin
               cnt   <= CW'(MEM_LAT - 1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  pc_out  <= WIDTH'(mem_rdata);
                  exc_ack <= 1'b1;
                  state   <= IDLE;
               end else cnt <= cnt - CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pc_source_unit.sv
// tb_pc_source_unit: directed tests of PC selection, exception entry and reset abort
module tb_pc_source_unit;
   logic clk = 0, reset = 0;
   logic [2:0] pc_sel = '0;
   logic [31:0] src [4];
   logic [127:0] src_bus;
   logic pc_write = 0, pc_write_cond = 0, cond_true = 0, exc_req = 0;
   logic [1:0] exc_cause = '0;
   logic [7:0] mem_rdata = '0;
   logic [31:0] pc_out, epc_out, mem_addr;
   logic mem_req, busy, exc_ack, sel_err;
   int errs = 0, checks = 0;
   assign src_bus = {src[3], src[2], src[1], src[0]};
   pc_source_unit dut (
      .clk(clk), .reset(reset), .pc_sel(pc_sel), .src_bus(src_bus),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
      .exc_req(exc_req), .exc_cause(exc_cause), .mem_rdata(mem_rdata),
      .pc_out(pc_out), .epc_out(epc_out), .mem_req(mem_req), .mem_addr(mem_addr),
      .busy(busy), .exc_ack(exc_ack), .sel_err(sel_err)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      reset = 1; pc_write = 1; pc_sel = 3'd1; src[1] = 32'hDEAD_BEEF;
      tick();
      reset = 0; pc_write = 0;
      checks++; if (pc_out !== 32'h0) begin errs++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
      checks++; if (epc_out !== 32'h0) begin errs++; $display("FAIL reset_epc got=%h exp=%h", epc_out, 32'h0); end
      checks++; if ({busy, mem_req, exc_ack, sel_err} !== 4'b0) begin errs++; $display("FAIL reset_flags got=%b exp=%b", {busy, mem_req, exc_ack, sel_err}, 4'b0); end
      checks++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got=%h exp=%h", mem_addr, 32'h0); end
   endtask
   task automatic test_load();
      src[2] = 32'h0040_0010; pc_sel = 3'd2; pc_write = 1;
      tick();
      pc_write = 0;
      checks++; if (pc_out !== 32'h0040_0010) begin errs++; $display("FAIL load_src2 got=%h exp=%h", pc_out, 32'h0040_0010); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL load_busy got=%b exp=%b", busy, 1'b0); end
   endtask
   task automatic test_cond();
      src[1] = 32'h80; pc_sel = 3'd1; pc_write_cond = 1; cond_true = 0;
      tick();
      checks++; if (pc_out !== 32'h0040_0010) begin errs++; $display("FAIL cond_false got=%h exp=%h", pc_out, 32'h0040_0010); end
      cond_true = 1;
      tick();
      pc_write_cond = 0;
      checks++; if (pc_out !== 32'h80) begin errs++; $display("FAIL cond_true got=%h exp=%h", pc_out, 32'h80); end
      pc_sel = 3'd0; src[0] = 32'h1234;
      tick();
      checks++; if (pc_out !== 32'h80) begin errs++; $display("FAIL no_load_hold got=%h exp=%h", pc_out, 32'h80); end
      cond_true = 0;
   endtask
   task automatic test_back_to_back();
      src[0] = 32'h11; src[1] = 32'h22; src[3] = 32'h44;
      pc_write = 1; pc_sel = 3'd0;
      tick();
      checks++; if (pc_out !== 32'h11) begin errs++; $display("FAIL b2b_0 got=%h exp=%h", pc_out, 32'h11); end
      pc_sel = 3'd3;
      tick();
      checks++; if (pc_out !== 32'h44) begin errs++; $display("FAIL b2b_3 got=%h exp=%h", pc_out, 32'h44); end
      pc_sel = 3'd1;
      tick();
      pc_write = 0;
      checks++; if (pc_out !== 32'h22) begin errs++; $display("FAIL b2b_1 got=%h exp=%h", pc_out, 32'h22); end
   endtask
   task automatic test_exception();
      src[0] = 32'h100; pc_sel = 3'd0; pc_write = 1;
      tick();
      exc_req = 1; exc_cause = 2'd1; mem_rdata = 8'h5C; src[0] = 32'h999;
      tick();
      exc_req = 0;
      checks++; if (pc_out !== 32'h100) begin errs++; $display("FAIL exc_load_suppressed got=%h exp=%h", pc_out, 32'h100); end
      checks++; if (epc_out !== 32'hFC) begin errs++; $display("FAIL exc_epc got=%h exp=%h", epc_out, 32'hFC); end
      checks++; if ({busy, mem_req, exc_ack} !== 3'b110) begin errs++; $display("FAIL exc_fetch_flags got=%b exp=%b", {busy, mem_req, exc_ack}, 3'b110); end
      checks++; if (mem_addr !== 32'd254) begin errs++; $display("FAIL exc_addr got=%h exp=%h", mem_addr, 32'd254); end
      exc_req = 1; exc_cause = 2'd2;
      tick();
      checks++; if ({busy, mem_req, exc_ack} !== 3'b100) begin errs++; $display("FAIL exc_wait_flags got=%b exp=%b", {busy, mem_req, exc_ack}, 3'b100); end
      checks++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL exc_wait_addr got=%h exp=%h", mem_addr, 32'h0); end
      checks++; if (pc_out !== 32'h100) begin errs++; $display("FAIL exc_busy_hold got=%h exp=%h", pc_out, 32'h100); end
      tick();
      exc_req = 0; pc_write = 0;
      checks++; if ({busy, exc_ack} !== 2'b01) begin errs++; $display("FAIL exc_ack got=%b exp=%b", {busy, exc_ack}, 2'b01); end
      checks++; if (pc_out !== 32'h5C) begin errs++; $display("FAIL exc_handler_pc got=%h exp=%h", pc_out, 32'h5C); end
      tick();
      checks++; if ({busy, mem_req, exc_ack} !== 3'b000) begin errs++; $display("FAIL exc_not_queued got=%b exp=%b", {busy, mem_req, exc_ack}, 3'b000); end
      checks++; if (epc_out !== 32'hFC) begin errs++; $display("FAIL exc_epc_kept got=%h exp=%h", epc_out, 32'hFC); end
   endtask
   task automatic test_epc_wrap();
      src[3] = 32'h0; pc_sel = 3'd3; pc_write = 1;
      tick();
      pc_write = 0; exc_req = 1; exc_cause = 2'd2; mem_rdata = 8'h10;
      tick();
      exc_req = 0;
      checks++; if (epc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_epc got=%h exp=%h", epc_out, 32'hFFFF_FFFC); end
      checks++; if (mem_addr !== 32'd255) begin errs++; $display("FAIL wrap_addr got=%h exp=%h", mem_addr, 32'd255); end
      tick();
      tick();
      checks++; if (pc_out !== 32'h10 || exc_ack !== 1'b1) begin errs++; $display("FAIL wrap_handler got=%h/%b exp=%h/%b", pc_out, exc_ack, 32'h10, 1'b1); end
      pc_sel = 3'd4; pc_write = 1;
      tick();
      pc_write = 0;
      checks++; if (pc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL load_epc got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
      checks++; if (sel_err !== 1'b0) begin errs++; $display("FAIL load_epc_selerr got=%b exp=%b", sel_err, 1'b0); end
   endtask
   task automatic test_sel_err();
      pc_sel = 3'd5; pc_write = 1;
      tick();
      pc_write = 0;
      checks++; if (pc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL selerr_hold got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
      checks++; if (sel_err !== 1'b1) begin errs++; $display("FAIL selerr_pulse got=%b exp=%b", sel_err, 1'b1); end
      tick();
      checks++; if (sel_err !== 1'b0) begin errs++; $display("FAIL selerr_single got=%b exp=%b", sel_err, 1'b0); end
      pc_sel = 3'd7; pc_write_cond = 1; cond_true = 1;
      tick();
      pc_write_cond = 0; cond_true = 0;
      checks++; if (sel_err !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL selerr_cond got=%b/%h exp=%b/%h", sel_err, pc_out, 1'b1, 32'hFFFF_FFFC); end
   endtask
   task automatic test_reset_abort();
      pc_sel = 3'd0;
      exc_req = 1; exc_cause = 2'd3; mem_rdata = 8'h77;
      tick();
      exc_req = 0;
      checks++; if (mem_addr !== 32'd253) begin errs++; $display("FAIL cause3_addr got=%h exp=%h", mem_addr, 32'd253); end
      tick();
      checks++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_in_wait got=%b exp=%b", busy, 1'b1); end
      reset = 1;
      tick();
      reset = 0;
      checks++; if (pc_out !== 32'h0 || epc_out !== 32'h0) begin errs++; $display("FAIL abort_regs got=%h/%h exp=%h/%h", pc_out, epc_out, 32'h0, 32'h0); end
      checks++; if ({busy, mem_req, exc_ack} !== 3'b000) begin errs++; $display("FAIL abort_flags got=%b exp=%b", {busy, mem_req, exc_ack}, 3'b000); end
      tick();
      checks++; if (exc_ack !== 1'b0 || pc_out !== 32'h0) begin errs++; $display("FAIL abort_no_ack got=%b/%h exp=%b/%h", exc_ack, pc_out, 1'b0, 32'h0); end
   endtask
   initial begin
      for (int i = 0; i < 4; i++) src[i] = '0;
      test_reset();
      test_load();
      test_cond();
      test_back_to_back();
      test_exception();
      test_epc_wrap();
      test_sel_err();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
